// File: rtl/uart_xcvr.sv
// UART transceiver: NCO-timed TX and RX FSMs sharing one 16x oversample tick,
// with a synchronised, glitch-filtered RX front end and framing/parity/break status.
module uart_xcvr #(
  parameter int DataWidth   = 8,
  parameter int NcoWidth    = 16,
  parameter int GlitchDepth = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NcoWidth-1:0]  nco_i,
  input  logic                 parity_en_i,
  input  logic                 parity_odd_i,
  input  logic                 stop2_i,
  input  logic [DataWidth-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic                 tx_o,
  input  logic                 rx_i,
  output logic [DataWidth-1:0] rx_data_o,
  output logic                 rx_valid_o,
  output logic                 rx_parity_err_o,
  output logic                 rx_frame_err_o,
  output logic                 rx_break_o,
  output logic                 tx_idle_o,
  output logic                 rx_idle_o
);
  localparam int BitW = $clog2(DataWidth);
  localparam int GlW  = $clog2(GlitchDepth + 1);
  localparam logic [BitW-1:0] LastBit = BitW'(DataWidth - 1);
  localparam logic [GlW-1:0]  GltLast = GlW'(GlitchDepth - 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAITHIGH} rx_state_e;

  logic [NcoWidth:0] acc_q;
  logic              tick;
  assign tick = acc_q[NcoWidth];

  tx_state_e tx_state_q, tx_state_d;
  logic [3:0]           tx_tick_q, tx_tick_d;
  logic [BitW-1:0]      tx_bit_q, tx_bit_d;
  logic [DataWidth-1:0] tx_shift_q, tx_shift_d;
  logic tx_par_q, tx_par_d, tx_pen_q, tx_pen_d, tx_stop2_q, tx_stop2_d;
  logic tx_second_q, tx_second_d, tx_q, tx_d, tx_end;

  rx_state_e rx_state_q, rx_state_d;
  logic rx_s1_q, rx_s2_q, rx_filt_q, rx_filt_d, rx_prev_q;
  logic [GlW-1:0]       glt_cnt_q, glt_cnt_d;
  logic [3:0]           rx_tick_q, rx_tick_d;
  logic [BitW-1:0]      rx_bit_q, rx_bit_d;
  logic [DataWidth-1:0] rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic rx_pbit_q, rx_pbit_d, rx_pen_q, rx_pen_d, rx_odd_q, rx_odd_d;
  logic rx_valid_q, rx_valid_d, rx_perr_q, rx_perr_d, rx_ferr_q, rx_ferr_d, rx_brk_q, rx_brk_d;
  logic rx_mid, rx_end;

  // tx_valid_i/tx_ready_o: a byte transfers on any cycle where both are high;
  // tx_ready_o depends only on state, never combinationally on tx_valid_i.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_tick_d   = tick ? tx_tick_q + 4'd1 : tx_tick_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    tx_par_d    = tx_par_q;
    tx_pen_d    = tx_pen_q;
    tx_stop2_d  = tx_stop2_q;
    tx_second_d = tx_second_q;
    tx_end      = tick && (tx_tick_q == 4'd15);
    case (tx_state_q)
      TX_IDLE: if (tx_valid_i) begin
        tx_state_d = TX_START;
        tx_tick_d  = '0;
        tx_shift_d = tx_data_i;
        tx_par_d   = (^tx_data_i) ^ parity_odd_i;
        tx_pen_d   = parity_en_i;
        tx_stop2_d = stop2_i;
      end
      TX_START: if (tx_end) begin
        tx_state_d = TX_DATA;
        tx_bit_d   = '0;
      end
      TX_DATA: if (tx_end) begin
        tx_shift_d = tx_shift_q >> 1;
        tx_bit_d   = tx_bit_q + 1'b1;
        if (tx_bit_q == LastBit) begin
          tx_state_d  = tx_pen_q ? TX_PARITY : TX_STOP;
          tx_second_d = 1'b0;
        end
      end
      TX_PARITY: if (tx_end) begin
        tx_state_d  = TX_STOP;
        tx_second_d = 1'b0;
      end
      TX_STOP: if (tx_end) begin
        if (tx_stop2_q && !tx_second_q) tx_second_d = 1'b1;
        else                            tx_state_d  = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // Line level follows the next state so tx_o is a clean register output.
    case (tx_state_d)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = tx_shift_d[0];
      TX_PARITY: tx_d = tx_par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  always_comb begin
    glt_cnt_d = '0;
    rx_filt_d = rx_filt_q;
    if (rx_s2_q != rx_filt_q) begin
      if (glt_cnt_q == GltLast) rx_filt_d = rx_s2_q;
      else                      glt_cnt_d = glt_cnt_q + 1'b1;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_tick_d  = tick ? rx_tick_q + 4'd1 : rx_tick_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_pbit_d  = rx_pbit_q;
    rx_pen_d   = rx_pen_q;
    rx_odd_d   = rx_odd_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    rx_brk_d   = rx_brk_q;
    rx_mid     = tick && (rx_tick_q == 4'd7);
    rx_end     = tick && (rx_tick_q == 4'd15);
    case (rx_state_q)
      RX_IDLE: if (rx_prev_q && !rx_filt_q) begin
        rx_state_d = RX_START;
        rx_tick_d  = '0;
        rx_pen_d   = parity_en_i;
        rx_odd_d   = parity_odd_i;
      end
      RX_START: if (rx_mid) begin
        // Re-zero at the start-bit centre so every later 16th tick lands mid-bit.
        rx_state_d = rx_filt_q ? RX_IDLE : RX_DATA;
        rx_tick_d  = '0;
        rx_bit_d   = '0;
      end
      RX_DATA: if (rx_end) begin
        rx_shift_d = {rx_filt_q, rx_shift_q[DataWidth-1:1]};
        rx_bit_d   = rx_bit_q + 1'b1;
        if (rx_bit_q == LastBit) rx_state_d = rx_pen_q ? RX_PARITY : RX_STOP;
      end
      RX_PARITY: if (rx_end) begin
        rx_pbit_d  = rx_filt_q;
        rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_end) begin
        rx_valid_d = 1'b1;
        rx_data_d  = rx_shift_q;
        rx_perr_d  = rx_pen_q && (rx_pbit_q != ((^rx_shift_q) ^ rx_odd_q));
        rx_ferr_d  = !rx_filt_q;
        rx_brk_d   = !rx_filt_q && (rx_shift_q == '0) && (!rx_pen_q || !rx_pbit_q);
        rx_state_d = rx_filt_q ? RX_IDLE : RX_WAITHIGH;
      end
      RX_WAITHIGH: if (rx_filt_q) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q       <= '0;
      tx_state_q  <= TX_IDLE;
      tx_tick_q   <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      tx_par_q    <= 1'b0;
      tx_pen_q    <= 1'b0;
      tx_stop2_q  <= 1'b0;
      tx_second_q <= 1'b0;
      tx_q        <= 1'b1;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_filt_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      glt_cnt_q   <= '0;
      rx_state_q  <= RX_IDLE;
      rx_tick_q   <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_pbit_q   <= 1'b0;
      rx_pen_q    <= 1'b0;
      rx_odd_q    <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_perr_q   <= 1'b0;
      rx_ferr_q   <= 1'b0;
      rx_brk_q    <= 1'b0;
    end else begin
      acc_q       <= {1'b0, acc_q[NcoWidth-1:0]} + {1'b0, nco_i};
      tx_state_q  <= tx_state_d;
      tx_tick_q   <= tx_tick_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_par_q    <= tx_par_d;
      tx_pen_q    <= tx_pen_d;
      tx_stop2_q  <= tx_stop2_d;
      tx_second_q <= tx_second_d;
      tx_q        <= tx_d;
      rx_s1_q     <= rx_i;
      rx_s2_q     <= rx_s1_q;
      rx_filt_q   <= rx_filt_d;
      rx_prev_q   <= rx_filt_q;
      glt_cnt_q   <= glt_cnt_d;
      rx_state_q  <= rx_state_d;
      rx_tick_q   <= rx_tick_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_pbit_q   <= rx_pbit_d;
      rx_pen_q    <= rx_pen_d;
      rx_odd_q    <= rx_odd_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_perr_q   <= rx_perr_d;
      rx_ferr_q   <= rx_ferr_d;
      rx_brk_q    <= rx_brk_d;
    end
  end

  assign tx_o            = tx_q;
  assign tx_ready_o      = (tx_state_q == TX_IDLE);
  assign tx_idle_o       = (tx_state_q == TX_IDLE);
  assign rx_idle_o       = (rx_state_q == RX_IDLE);
  assign rx_data_o       = rx_data_q;
  assign rx_valid_o      = rx_valid_q;
  assign rx_parity_err_o = rx_perr_q;
  assign rx_frame_err_o  = rx_ferr_q;
  assign rx_break_o      = rx_brk_q;
endmodule

// File: tb/tb_uart_xcvr.sv
// Bench for uart_xcvr: line-level TX decoder and RX frame scoreboard, both fed
// from a frame-level reference model; nco=4096 gives a 256-clock bit.
`timescale 1ns/1ps
module tb_uart_xcvr;
  localparam int W   = 8;
  localparam int BIT = 256;

  typedef struct packed {logic [7:0] d; logic pen; logic odd; logic s2;} tx_frame_t;

  logic clk = 1'b0, rst_ni = 1'b0;
  logic [15:0] nco_i = 16'd4096;
  logic parity_en_i = 0, parity_odd_i = 0, stop2_i = 0, tx_valid_i = 0;
  logic [W-1:0] tx_data_i = '0;
  logic tx_ready_o, tx_o, rx_i, rx_valid_o, rx_parity_err_o, rx_frame_err_o, rx_break_o;
  logic tx_idle_o, rx_idle_o;
  logic [W-1:0] rx_data_o;
  logic loop_en = 1'b0, rx_drv = 1'b1;

  int n_cmp = 0, n_fail = 0;
  logic [10:0] exp_q[$];   // {break, frame_err, parity_err, data}
  tx_frame_t tx_exp_q[$];
  bit tx_mon_en = 1'b1, dec_busy = 1'b0;
  time rise_t = 0, high_len = 0;

  always #5 clk = ~clk;
  assign rx_i = loop_en ? tx_o : rx_drv;

  uart_xcvr #(.DataWidth(W), .NcoWidth(16), .GlitchDepth(2)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .nco_i(nco_i), .parity_en_i(parity_en_i),
    .parity_odd_i(parity_odd_i), .stop2_i(stop2_i), .tx_data_i(tx_data_i),
    .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o), .tx_o(tx_o), .rx_i(rx_i),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_parity_err_o(rx_parity_err_o),
    .rx_frame_err_o(rx_frame_err_o), .rx_break_o(rx_break_o),
    .tx_idle_o(tx_idle_o), .rx_idle_o(rx_idle_o)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    n_cmp++;
    if (got < lo || got > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  // Reference model: what a receiver must report for a frame with these line bits.
  function automatic logic [10:0] rx_expect(logic [7:0] d, logic pen, logic odd, logic pbit, logic stopb);
    logic perr, ferr, brk;
    perr = pen && (pbit != ((^d) ^ odd));
    ferr = !stopb;
    brk  = ferr && (d == 8'd0) && (!pen || !pbit);
    return {brk, ferr, perr, d};
  endfunction

  // Reference model: line bits in transmit order (bit 0 = start).
  function automatic logic [11:0] line_bits(tx_frame_t f);
    logic [11:0] b;
    int p;
    b = '0;
    for (int i = 0; i < 8; i++) b[1+i] = f.d[i];
    p = 9;
    if (f.pen) begin b[p] = (^f.d) ^ f.odd; p++; end
    b[p] = 1'b1; p++;
    if (f.s2) b[p] = 1'b1;
    return b;
  endfunction

  // TX line monitor
  tx_frame_t dec_f;
  logic [11:0] dec_got;
  int dec_n;
  always begin
    @(negedge tx_o);
    if (tx_mon_en && rst_ni) begin
      dec_busy = 1'b1;
      if (tx_exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL tx_unexpected_frame: start bit seen, expected none");
      end else begin
        dec_f = tx_exp_q.pop_front();
        dec_n = 10 + int'(dec_f.pen) + int'(dec_f.s2);
        dec_got = '0;
        repeat (BIT/2) @(negedge clk);
        for (int i = 0; i < dec_n; i++) begin
          dec_got[i] = tx_o;
          if (i < dec_n - 1) repeat (BIT) @(negedge clk);
        end
        check("tx_line_bits", {20'd0, dec_got}, {20'd0, line_bits(dec_f)});
      end
      dec_busy = 1'b0;
    end
  end

  always @(posedge tx_o) rise_t = $time;
  always @(negedge tx_o) high_len = ($time - rise_t) / 10;

  // RX scoreboard monitor
  logic [10:0] mon_e;
  always @(negedge clk) begin
    if (rst_ni && rx_valid_o) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL rx_unexpected_frame: got %0h, expected no frame",
                 {rx_break_o, rx_frame_err_o, rx_parity_err_o, rx_data_o});
      end else begin
        mon_e = exp_q.pop_front();
        check("rx_frame", {21'd0, rx_break_o, rx_frame_err_o, rx_parity_err_o, rx_data_o},
              {21'd0, mon_e});
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic pen, input logic odd, input logic s2,
                      input bit keep, input bit expect_frame);
    int i;
    @(negedge clk);
    tx_data_i = d; parity_en_i = pen; parity_odd_i = odd; stop2_i = s2; tx_valid_i = 1'b1;
    if (expect_frame) begin
      tx_exp_q.push_back('{d: d, pen: pen, odd: odd, s2: s2});
      if (loop_en) exp_q.push_back(rx_expect(d, pen, odd, (^d) ^ odd, 1'b1));
    end
    for (i = 0; i < 8000 && !tx_ready_o; i++) @(negedge clk);
    check("tx_accept_timeout", (i >= 8000), 0);
    @(posedge clk);
    @(negedge clk);
    if (!keep) tx_valid_i = 1'b0;
    check("tx_start_after_accept", tx_o, 0);
  endtask

  task automatic drive_rx(input logic [7:0] d, input logic pen, input logic odd,
                          input logic flip, input logic stopb);
    logic [11:0] b;
    logic pbit;
    int n;
    @(negedge clk);
    parity_en_i = pen; parity_odd_i = odd;
    pbit = (^d) ^ odd ^ flip;
    b = '0;
    for (int i = 0; i < 8; i++) b[1+i] = d[i];
    n = 9;
    if (pen) begin b[n] = pbit; n++; end
    b[n] = stopb; n++;
    exp_q.push_back(rx_expect(d, pen, odd, pbit, stopb));
    for (int i = 0; i < n; i++) begin
      rx_drv = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic wait_quiet();
    int i;
    for (i = 0; i < 20000; i++) begin
      if (exp_q.size() == 0 && tx_exp_q.size() == 0 && !dec_busy && tx_idle_o && rx_idle_o) break;
      @(negedge clk);
    end
    check("quiesce_timeout", (i >= 20000), 0);
    if (i >= 20000) begin exp_q.delete(); tx_exp_q.delete(); end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit low_seen;
    logic [7:0] rd;
    logic rp, ro, rs;

    repeat (3) @(negedge clk);
    check("rst_tx_o", tx_o, 1);
    check("rst_tx_ready", tx_ready_o, 1);
    check("rst_idle_flags", {tx_idle_o, rx_idle_o}, 2'b11);
    check("rst_rx_valid", rx_valid_o, 0);
    check("rst_rx_data", rx_data_o, 0);
    check("rst_err_flags", {rx_parity_err_o, rx_frame_err_o, rx_break_o}, 0);
    rst_ni = 1'b1;
    repeat (4) @(negedge clk);

    loop_en = 1'b1;
    send(8'hA5, 0, 0, 0, 0, 1);
    cnt = 0;
    while (!tx_ready_o && cnt < 6000) begin cnt++; @(negedge clk); end
    check_range("tx_ready_low_8n1", cnt, 2544, 2576);
    wait_quiet();

    send(8'h07, 1, 0, 0, 0, 1);
    wait_quiet();

    loop_en = 1'b0;
    drive_rx(8'h07, 1, 0, 1, 1);
    wait_quiet();
    drive_rx(8'h3C, 0, 0, 0, 0);
    wait_quiet();

    @(negedge clk);
    parity_en_i = 1'b0;
    exp_q.push_back(rx_expect(8'h00, 0, 0, 0, 0));
    rx_drv = 1'b0;
    repeat (11*BIT) @(negedge clk);
    check("break_one_frame_seen", exp_q.size(), 0);
    check("break_waithigh_not_idle", rx_idle_o, 0);
    repeat (BIT) @(negedge clk);
    rx_drv = 1'b1;
    repeat (64) @(negedge clk);
    check("break_release_idle", rx_idle_o, 1);
    wait_quiet();

    rx_drv = 1'b0;
    @(negedge clk);
    rx_drv = 1'b1;
    low_seen = 0;
    repeat (16) begin @(negedge clk); if (!rx_idle_o) low_seen = 1; end
    check("glitch_1clk_ignored", low_seen, 0);
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    low_seen = 0;
    repeat (300) begin @(negedge clk); if (!rx_idle_o) low_seen = 1; end
    check("glitch_3clk_start_seen", low_seen, 1);
    check("glitch_3clk_false_start_idle", rx_idle_o, 1);
    wait_quiet();

    loop_en = 1'b1;
    send(8'h11, 0, 0, 1, 1, 1);
    send(8'h22, 0, 0, 1, 0, 1);
    check_range("b2b_stop_gap_8n2", int'(high_len), 512, 514);
    wait_quiet();

    for (int k = 0; k < 6; k++) begin
      rd = 8'($urandom_range(0, 255));
      rp = 1'($urandom_range(0, 1));
      ro = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      send(rd, rp, ro, rs, 0, 1);
      wait_quiet();
    end

    tx_mon_en = 1'b0;
    send(8'h5A, 1, 1, 0, 0, 0);
    repeat (4*BIT) @(negedge clk);
    #2 rst_ni = 1'b0;
    #1;
    check("midrst_tx_o", tx_o, 1);
    check("midrst_idle_flags", {tx_idle_o, rx_idle_o}, 2'b11);
    check("midrst_rx_valid", rx_valid_o, 0);
    check("midrst_tx_ready", tx_ready_o, 1);
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    repeat (32) @(negedge clk);
    tx_mon_en = 1'b1;
    send(8'hC3, 1, 0, 0, 0, 1);
    wait_quiet();

    check("scoreboard_empty", exp_q.size() + tx_exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_xcvr.md
# uart_xcvr

Parametrised, synthesisable UART transceiver for use as an on-chip loopback partner and emulation-side stand-in for the UART DV agent. It drives `tx_o` from a valid/ready byte stream and recovers frames from an asynchronous `rx_i`. Frame width, parity, stop bits, baud and RX glitch rejection are configurable. It reports framing, parity and break conditions. It exposes TX/RX idle flags so benches can wait for quiescence.

## Interface
- `DataWidth`, default 8: data bits per frame; legal range 5..9.
- `NcoWidth`, default 16: width of the baud NCO increment.
- `GlitchDepth`, default 2: consecutive identical `clk_i` samples required before the filtered RX level changes; minimum 1.
- `clk_i`  in  1  system clock.
- `rst_ni`  in  1  reset; one clock; reset is asynchronous and active-low.
- `nco_i`  in  NcoWidth  per-clock NCO increment; carry-out produces the 16x oversample tick.
- `parity_en_i`  in  1  parity bit present.
- `parity_odd_i`  in  1  1 = odd parity, 0 = even parity.
- `stop2_i`  in  1  TX sends two stop bits.
- `tx_data_i`  in  DataWidth  byte to send.
- `tx_valid_i`  in  1  TX request.
- `tx_ready_o`  out  1  TX can accept.
- `tx_o`  out  1  serial output; idles high.
- `rx_i`  in  1  asynchronous serial input.
- `rx_data_o`  out  DataWidth  last received data.
- `rx_valid_o`  out  1  single-cycle frame-done pulse.
- `rx_parity_err_o`, `rx_frame_err_o`, `rx_break_o`  out  1 each  status qualified by `rx_valid_o`.
- `tx_idle_o`, `rx_idle_o`  out  1 each  FSM in IDLE.

## Operation
- **Baud NCO.**
  - `acc` is NcoWidth+1 bits wide. Each clock: `acc <= acc[NcoWidth-1:0] + nco_i`.
  - `tick` = `acc[NcoWidth]`.
  - One bit time = 16 ticks. Baud = f_clk·nco_i / 2^NcoWidth / 16.
  - `nco_i` = 0 freezes both FSMs in their current state.
- **TX FSM** (IDLE → START → DATA → PARITY → STOP → IDLE).
  - `tx_ready_o` = 1 only in IDLE.
  - Accept on `tx_valid_i & tx_ready_o`. In that cycle, latch `tx_data_i`, `parity_en_i`, `parity_odd_i` and `stop2_i`, and clear the tick counter.
  - Data is sent LSB first.
  - Parity bit = XOR(data) ^ `parity_odd`. The PARITY state is skipped when parity is disabled.
  - STOP lasts 1 or 2 bit times, per the latched `stop2_i`.
  - Each state ends on its 16th tick.
- **RX front end.**
  - 2-flop synchroniser, reset to 1.
  - Glitch filter: the filtered level takes the new value only after GlitchDepth consecutive clocks of that value. Filter output resets to 1.
- **RX FSM** (IDLE → START → DATA → PARITY → STOP → (WAITHIGH) → IDLE).
  - IDLE: a filtered falling edge enters START, clears the tick counter, and latches the parity configuration.
  - START: sample on the 8th tick. If the sample is high, it is a false start: return to IDLE with no `rx_valid_o`.
  - DATA and PARITY: sample every 16th tick thereafter (bit centre).
  - STOP: checks only the first stop bit; RX ignores `stop2_i`.
  - On the stop sample, on the next clock:
    - Pulse `rx_valid_o`.
    - Update `rx_data_o`.
    - Set `rx_parity_err_o` = received parity mismatch.
    - Set `rx_frame_err_o` = stop bit sampled 0.
    - Set `rx_break_o` = frame error AND all data bits 0 AND parity bit 0 (or parity disabled).
  - Error flags hold until the next `rx_valid_o`.
  - If the stop bit is 0, go to WAITHIGH and stay there until the filtered line is 1, so a held break yields exactly one frame.
- **Idle flags.** `tx_idle_o` / `rx_idle_o` = 1 exactly when the respective FSM is in IDLE.

## Timing
- **Reset values:** `tx_o`=1, `tx_ready_o`=1, `tx_idle_o`=1, `rx_idle_o`=1, `rx_valid_o`=0, `rx_data_o`=0, all error flags 0, `acc`=0, both FSMs in IDLE.
- **TX latency:** `tx_o` falls on the clock after accept. `tx_ready_o` rises on the clock after the last stop tick.
  - The first bit may be shorter than later bits by up to one tick period, because `acc` is not cleared.
- **RX latency:** `rx_i` to filtered edge is 2 + GlitchDepth clocks. `rx_valid_o` occurs 1 clock after the stop-sample tick.
- **Simultaneous events:** a TX accept and an RX edge in the same cycle are independent; the two FSMs share only the tick.
- **Mid-frame configuration changes:** changes to `parity_*` / `stop2_i` have no effect until the next frame. `nco_i` changes take effect immediately.
- **Reset mid-frame:** all outputs return to their reset values asynchronously; no partial `rx_valid_o`.

## Test plan
- **TX/RX loopback.** `tx_o`→`rx_i`, nco=4096 (tick every 16 clk, bit = 256 clk), 8N1, send 0xA5 → `rx_valid_o` once with 0xA5, no errors. `tx_ready_o` low for 2560 clk ±16.
- **Even parity.** Even parity, send 0x07 → parity bit driven 1. RX reports no parity error. Flip that bit externally → `rx_parity_err_o`=1.
- **Framing error and break.**
  - Drive a frame with stop=0 and data 0x3C → `rx_frame_err_o`=1, `rx_break_o`=0.
  - Hold `rx_i` low for 12 bit times → exactly one `rx_valid_o` with data 0, `rx_frame_err_o`=1, `rx_break_o`=1. No further frame until the line returns high.
- **Glitch rejection.** GlitchDepth=2, 1-clk low pulse on idle line → `rx_idle_o` stays 1. A 3-clk pulse shorter than half a bit → false start, no `rx_valid_o`.
- **Back-to-back TX.** `tx_valid_i` held high with 0x11 then 0x22, 8N2 → two frames separated by exactly 2 stop bit times. Both received correctly.
- **Reset mid-frame.** Assert `rst_ni` during TX DATA and RX DATA → `tx_o`=1, both idle flags 1, no `rx_valid_o`. A subsequent frame is received correctly.
